gpio_apb_requester: RTL and testbench

APB4 requester (initiator) that turns a valid/ready command stream into single APB transfers toward APB completers such as the GPIO controller's register file. It is used by the block-level bench, by boot/sequencer logic and by any on-chip agent that programs GPIO CSRs. It returns read data and error status on a valid/ready response channel. A per-transfer timeout guards against a hung completer.

---
 rtl/gpio_apb_requester_pkg.sv | 47 ++++
 rtl/gpio_apb_requester_timeout.sv | 52 +++++
 rtl/gpio_apb_requester.sv | 192 +++++++++++++++++++
 tb/tb_gpio_apb_requester.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_apb_requester_pkg.sv
// Shared types for the GPIO APB requester.
//   state_e : requester FSM states (IDLE, SETUP, ACCESS, RESP).
//   cmd_t   : captured command (address, direction, write data, strobes).
//   rsp_t   : captured response (read data, error, timeout flag).
// The field widths follow the GPIO CSR window (12-bit byte address,
// 32-bit data). The top converts its port widths into these fields.
package gpio_apb_requester_pkg;

    localparam int unsigned PKG_ADDR_W = 12;
    localparam int unsigned PKG_DATA_W = 32;
    localparam int unsigned PKG_STRB_W = PKG_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic                  write;
        logic [PKG_DATA_W-1:0] wdata;
        logic [PKG_STRB_W-1:0] strb;
    } cmd_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } rsp_t;

    // Reads never carry byte strobes onto the bus.
    function automatic logic [PKG_STRB_W-1:0] masked_strb(
        input logic                  write,
        input logic [PKG_STRB_W-1:0] strb
    );
        logic [PKG_STRB_W-1:0] result;
        if (write) begin
            result = strb;
        end else begin
            result = {PKG_STRB_W{1'b0}};
        end
        return result;
    endfunction

endpackage

// File: rtl/gpio_apb_requester_timeout.sv
// ACCESS-phase watchdog counter for the GPIO APB requester.
//   clk, rst_n : clock and asynchronous active-low reset.
//   clear      : zero the counter (asserted when a command is accepted).
//   enable     : one more ACCESS cycle passed without pready.
//   expire     : the cycle being counted now is the TIMEOUT_CYCLES-th one,
//                so the transfer must be abandoned at the next edge.
// TIMEOUT_CYCLES = 0 removes the counter and holds expire low.
module gpio_apb_requester_timeout
    import gpio_apb_requester_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs_s;
            assign unused_inputs_s = ^{clk, rst_n, clear, enable};
            assign expire          = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

            logic [CNT_W-1:0] count_r;

            // Saturating count of ACCESS cycles without pready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_r <= {CNT_W{1'b0}};
                end else if (clear) begin
                    count_r <= {CNT_W{1'b0}};
                end else if (enable && (count_r != CNT_MAX)) begin
                    count_r <= count_r + CNT_W'(1);
                end else begin
                    count_r <= count_r;
                end
            end

            // The counter already holds the previous idle cycles, so this
            // cycle is the one that reaches the limit.
            assign expire = enable && (count_r == LIMIT_M1);
        end
    endgenerate

endmodule

// File: rtl/gpio_apb_requester.sv
// APB4 requester: turns a valid/ready command stream into single APB
// transfers and returns read data / error status on a valid/ready
// response channel. One transfer is in flight at most; there is no
// command buffering.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_addr/cmd_write/cmd_wdata/cmd_strb  command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata/rsp_slverr/rsp_timeout   response payload
//   busy                               high whenever the FSM is not IDLE
//   paddr/pwrite/psel/penable/pstrb/pwdata  APB request outputs
//   prdata/pready/pslverr              APB completer inputs
// Every output is driven straight from a register.
module gpio_apb_requester
    import gpio_apb_requester_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pwrite,
    output logic                    psel,
    output logic                    penable,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_e state_r;
    state_e state_next_s;
    cmd_t   cmd_r;
    cmd_t   cmd_next_s;
    rsp_t   rsp_r;
    rsp_t   rsp_next_s;
    logic   rsp_valid_r;
    logic   rsp_valid_next_s;
    logic   psel_r;
    logic   psel_next_s;
    logic   penable_r;
    logic   penable_next_s;
    logic   cmd_ready_r;
    logic   busy_r;
    logic   accept_s;
    logic   wait_s;
    logic   expire_s;

    assign wait_s = (state_r == ACCESS) && !pready;

    gpio_apb_requester_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept_s),
        .enable (wait_s),
        .expire (expire_s)
    );

    // Next-state and next-register values for the transfer FSM.
    always_comb begin
        state_next_s     = state_r;
        cmd_next_s       = cmd_r;
        rsp_next_s       = rsp_r;
        rsp_valid_next_s = rsp_valid_r;
        psel_next_s      = 1'b0;
        penable_next_s   = 1'b0;
        accept_s         = 1'b0;

        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s         = 1'b1;
                    cmd_next_s.addr  = PKG_ADDR_W'(cmd_addr);
                    cmd_next_s.write = cmd_write;
                    cmd_next_s.wdata = PKG_DATA_W'(cmd_wdata);
                    cmd_next_s.strb  = masked_strb(cmd_write, PKG_STRB_W'(cmd_strb));
                    psel_next_s      = 1'b1;
                    state_next_s     = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end

            SETUP: begin
                psel_next_s    = 1'b1;
                penable_next_s = 1'b1;
                state_next_s   = ACCESS;
            end

            ACCESS: begin
                // pready wins over an expiring counter in the same cycle.
                if (pready) begin
                    if (cmd_r.write) begin
                        rsp_next_s.rdata = {PKG_DATA_W{1'b0}};
                    end else begin
                        rsp_next_s.rdata = PKG_DATA_W'(prdata);
                    end
                    rsp_next_s.slverr  = pslverr;
                    rsp_next_s.timeout = 1'b0;
                    rsp_valid_next_s   = 1'b1;
                    cmd_next_s.strb    = {PKG_STRB_W{1'b0}};
                    state_next_s       = RESP;
                end else if (expire_s) begin
                    // Recovery abort: the bus is released without pready.
                    rsp_next_s.rdata   = {PKG_DATA_W{1'b0}};
                    rsp_next_s.slverr  = 1'b1;
                    rsp_next_s.timeout = 1'b1;
                    rsp_valid_next_s   = 1'b1;
                    cmd_next_s.strb    = {PKG_STRB_W{1'b0}};
                    state_next_s       = RESP;
                end else begin
                    psel_next_s    = 1'b1;
                    penable_next_s = 1'b1;
                    state_next_s   = ACCESS;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next_s = 1'b0;
                    state_next_s     = IDLE;
                end else begin
                    rsp_valid_next_s = 1'b1;
                    state_next_s     = RESP;
                end
            end

            default: begin
                rsp_valid_next_s = 1'b0;
                cmd_next_s.strb  = {PKG_STRB_W{1'b0}};
                state_next_s     = IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_r       <= {$bits(cmd_t){1'b0}};
            rsp_r       <= {$bits(rsp_t){1'b0}};
            rsp_valid_r <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cmd_r       <= cmd_next_s;
            rsp_r       <= rsp_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            psel_r      <= psel_next_s;
            penable_r   <= penable_next_s;
            cmd_ready_r <= (state_next_s == IDLE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign busy        = busy_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = DATA_WIDTH'(rsp_r.rdata);
    assign rsp_slverr  = rsp_r.slverr;
    assign rsp_timeout = rsp_r.timeout;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign paddr       = ADDR_WIDTH'(cmd_r.addr);
    assign pwrite      = cmd_r.write;
    assign pwdata      = DATA_WIDTH'(cmd_r.wdata);
    assign pstrb       = STRB_WIDTH'(cmd_r.strb);

endmodule

// File: tb/tb_gpio_apb_requester.sv
// Self-checking bench for gpio_apb_requester (TIMEOUT_CYCLES = 8).
// A behavioural completer answers in the ACCESS phase after a chosen
// number of wait states; expected responses and latencies come from a
// small rule-based model of the transfer.
module tb_gpio_apb_requester;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int checks = 0;
    int errors = 0;

    // Observations of the last transfer driven by run_xfer.
    int            lat_setup, lat_access, lat_rsp;
    logic [AW-1:0] ob_paddr;
    logic          ob_pwrite;
    logic [DW-1:0] ob_pwdata;
    logic [SW-1:0] ob_pstrb;
    logic [DW-1:0] ob_rdata;
    logic          ob_slverr, ob_timeout;
    logic          apb_ok, hold_ok, xfer_done;

    always #5 clk = ~clk;

    gpio_apb_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .busy(busy),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: the completer answers on ACCESS cycle waits+1; if that
    // is beyond TO cycles (or never), the transfer times out after TO cycles.
    function automatic void model(input logic wr, input int waits, input logic err,
                                  input logic [DW-1:0] rd, output int lat,
                                  output logic [DW-1:0] e_rdata, output logic e_err,
                                  output logic e_to);
        e_to    = (waits < 0) || (waits >= TO);
        lat     = e_to ? 2 + TO : 3 + waits;
        e_rdata = (e_to || wr) ? 32'h0 : rd;
        e_err   = e_to ? 1'b1 : err;
    endfunction

    // Drives one command, plays the completer, and records what it saw.
    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                            input int waits, input logic err,
                            input logic [DW-1:0] rdata_in, input int hold);
        int guard;
        int c;
        int n_acc;
        lat_setup = -1; lat_access = -1; lat_rsp = -1;
        apb_ok = 1'b1; hold_ok = 1'b1; xfer_done = 1'b0;
        ob_paddr = '0; ob_pwrite = 1'b0; ob_pwdata = '0; ob_pstrb = '0;
        ob_rdata = '0; ob_slverr = 1'b0; ob_timeout = 1'b0;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr;
        cmd_wdata = wdata; cmd_strb = strb;
        rsp_ready = (hold == 0);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom); cmd_write = 1'($urandom);
        cmd_wdata = $urandom;      cmd_strb  = SW'($urandom);
        c = 1;
        n_acc = 0;
        while (c < 40 && !xfer_done) begin
            if (psel === 1'b1 && penable === 1'b0 && lat_setup < 0) lat_setup = c;
            if (psel === 1'b1 && penable === 1'b1) begin
                n_acc++;
                if (n_acc == 1) begin
                    lat_access = c;
                    ob_paddr = paddr; ob_pwrite = pwrite;
                    ob_pwdata = pwdata; ob_pstrb = pstrb;
                end else if ({paddr, pwrite, pwdata, pstrb} !==
                             {ob_paddr, ob_pwrite, ob_pwdata, ob_pstrb}) begin
                    apb_ok = 1'b0;
                end
                pready = (waits >= 0) && (n_acc == waits + 1);
            end else begin
                pready = 1'($urandom);
            end
            prdata  = pready && psel && penable ? rdata_in : $urandom;
            pslverr = pready && psel && penable ? err : 1'($urandom);
            if (cmd_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat_rsp = c;
                ob_rdata = rsp_rdata; ob_slverr = rsp_slverr; ob_timeout = rsp_timeout;
                if (psel !== 1'b0 || penable !== 1'b0 || pstrb !== '0) apb_ok = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    tick();
                    if ({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, cmd_ready, psel} !==
                        {1'b1, ob_rdata, ob_slverr, ob_timeout, 1'b0, 1'b0}) hold_ok = 1'b0;
                end
                rsp_ready = 1'b1;
                tick();
                if (rsp_valid !== 1'b0) hold_ok = 1'b0;
                rsp_ready = 1'b0;
                xfer_done = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #2;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy, paddr,
             pwrite, psel, penable, pstrb, pwdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rv=%b busy=%b psel=%b paddr=%h, required all 0",
                     cmd_ready, rsp_valid, busy, psel, paddr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy, psel} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b busy=%b psel=%b, required 1 0 0",
                     cmd_ready, busy, psel);
        end
    endtask

    task automatic test_write();
        run_xfer(12'h104, 1'b1, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0);
        checks++;
        if ({lat_setup, lat_access, lat_rsp} !== {32'd1, 32'd2, 32'd3}) begin
            errors++;
            $display("FAIL write_latency: got %0d/%0d/%0d, required 1/2/3",
                     lat_setup, lat_access, lat_rsp);
        end
        checks++;
        if ({ob_paddr, ob_pwrite, ob_pwdata, ob_pstrb} !== {12'h104, 1'b1, 32'hA5A5_0001, 4'hF}) begin
            errors++;
            $display("FAIL write_apb: got addr=%h wr=%b data=%h strb=%h, required 104 1 a5a50001 f",
                     ob_paddr, ob_pwrite, ob_pwdata, ob_pstrb);
        end
        checks++;
        if ({ob_rdata, ob_slverr, ob_timeout, apb_ok, hold_ok} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL write_rsp: got rdata=%h err=%b to=%b apb_ok=%b hold_ok=%b, required 0 0 0 1 1",
                     ob_rdata, ob_slverr, ob_timeout, apb_ok, hold_ok);
        end
    endtask

    task automatic test_read_wait();
        run_xfer(12'h040, 1'b0, 32'h5555_AAAA, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
        checks++;
        if ({ob_pstrb, ob_pwrite, ob_paddr, apb_ok} !== {4'h0, 1'b0, 12'h040, 1'b1}) begin
            errors++;
            $display("FAIL read_apb: got strb=%h wr=%b addr=%h stable=%b, required 0 0 040 1",
                     ob_pstrb, ob_pwrite, ob_paddr, apb_ok);
        end
        checks++;
        if (lat_rsp !== 6 || ob_rdata !== 32'h1234_5678 || ob_slverr !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: got lat=%0d rdata=%h err=%b, required 6 12345678 0",
                     lat_rsp, ob_rdata, ob_slverr);
        end
    endtask

    task automatic test_slverr_hold();
        run_xfer(12'h208, 1'b1, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0, 5);
        checks++;
        if ({ob_slverr, ob_timeout, ob_rdata, lat_rsp} !== {1'b1, 1'b0, 32'h0, 32'd4}) begin
            errors++;
            $display("FAIL slverr_rsp: got err=%b to=%b rdata=%h lat=%0d, required 1 0 0 4",
                     ob_slverr, ob_timeout, ob_rdata, lat_rsp);
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            errors++;
            $display("FAIL rsp_hold: got stable=%b, required 1", hold_ok);
        end
    endtask

    task automatic test_timeout();
        run_xfer(12'h3FC, 1'b0, 32'h0, 4'h0, -1, 1'b0, 32'hFFFF_FFFF, 0);
        checks++;
        if ({lat_rsp, ob_slverr, ob_timeout, ob_rdata, apb_ok} !==
            {32'(2 + TO), 1'b1, 1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_abort: got lat=%0d err=%b to=%b rdata=%h bus_ok=%b, required %0d 1 1 0 1",
                     lat_rsp, ob_slverr, ob_timeout, ob_rdata, apb_ok, 2 + TO);
        end
        run_xfer(12'h3F8, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 32'hCAFE_0008, 0);
        checks++;
        if ({lat_rsp, ob_slverr, ob_timeout, ob_rdata} !== {32'(2 + TO), 1'b0, 1'b0, 32'hCAFE_0008}) begin
            errors++;
            $display("FAIL timeout_edge: got lat=%0d err=%b to=%b rdata=%h, required %0d 0 0 cafe0008",
                     lat_rsp, ob_slverr, ob_timeout, ob_rdata, 2 + TO);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] q_addr [4];
        logic          q_wr   [4];
        logic [DW-1:0] got    [$];
        int            acc_t  [$];
        int            i;
        int            cyc;
        logic          acc;
        for (int k = 0; k < 4; k++) begin
            q_addr[k] = AW'($urandom) & 12'hFFC;
            q_wr[k]   = k[0];
        end
        i = 0;
        cyc = 0;
        rsp_ready = 1'b1;
        while (got.size() < 4 && cyc < 60) begin
            pready  = 1'b1;
            pslverr = 1'b0;
            prdata  = {20'h0, paddr} ^ 32'hC0DE_0000;
            if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
            cmd_valid = (i < 4);
            cmd_addr  = q_addr[i % 4];
            cmd_write = q_wr[i % 4];
            cmd_wdata = $urandom;
            cmd_strb  = 4'hF;
            acc = cmd_valid && (cmd_ready === 1'b1);
            tick();
            cyc++;
            if (acc) begin
                acc_t.push_back(cyc);
                i++;
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
        checks++;
        if (acc_t.size() != 4 || got.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d accepts %0d responses, required 4 4",
                     acc_t.size(), got.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (acc_t[k] - acc_t[k-1] != 4) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 4",
                             k, acc_t[k] - acc_t[k-1]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== (q_wr[k] ? 32'h0 : ({20'h0, q_addr[k]} ^ 32'hC0DE_0000))) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h, required %h", k, got[k],
                             q_wr[k] ? 32'h0 : ({20'h0, q_addr[k]} ^ 32'hC0DE_0000));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1; cmd_addr = 12'h010; cmd_write = 1'b1;
        cmd_wdata = 32'h7777_0000; cmd_strb = 4'hF; pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({psel, penable, busy} !== 3'b111) begin
            errors++;
            $display("FAIL mid_access: got psel=%b penable=%b busy=%b, required 1 1 1",
                     psel, penable, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got psel=%b penable=%b rv=%b busy=%b ready=%b, required all 0",
                     psel, penable, rsp_valid, busy, cmd_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        run_xfer(12'h020, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h0F0F_1234, 0);
        checks++;
        if ({lat_rsp, ob_rdata, ob_slverr, ob_timeout} !== {32'd5, 32'h0F0F_1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d rdata=%h err=%b to=%b, required 5 0f0f1234 0 0",
                     lat_rsp, ob_rdata, ob_slverr, ob_timeout);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic          wr, err;
        logic [DW-1:0] wd, rd, e_rdata;
        logic [SW-1:0] st;
        logic          e_err, e_to;
        int            waits, hold, e_lat;
        for (int n = 0; n < 30; n++) begin
            a = AW'($urandom); wr = 1'($urandom); err = 1'($urandom);
            wd = $urandom; rd = $urandom; st = SW'($urandom);
            waits = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 10));
            hold = int'($urandom_range(0, 2));
            run_xfer(a, wr, wd, st, waits, err, rd, hold);
            model(wr, waits, err, rd, e_lat, e_rdata, e_err, e_to);
            checks++;
            if (lat_rsp !== e_lat || ob_rdata !== e_rdata || ob_slverr !== e_err ||
                ob_timeout !== e_to || ob_paddr !== a || ob_pwrite !== wr ||
                ob_pwdata !== wd || ob_pstrb !== (wr ? st : 4'h0) ||
                apb_ok !== 1'b1 || hold_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand[%0d]: got lat=%0d rdata=%h err=%b to=%b addr=%h strb=%h ok=%b%b, required lat=%0d rdata=%h err=%b to=%b addr=%h strb=%h ok=11",
                         n, lat_rsp, ob_rdata, ob_slverr, ob_timeout, ob_paddr, ob_pstrb,
                         apb_ok, hold_ok, e_lat, e_rdata, e_err, e_to, a, wr ? st : 4'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
